// File: rtl/tx_rcfg_sequencer.sv
// HDMI TX bring-up sequencer: on a hot-plug/mode-change request it holds the TX
// resets, programs the TX PLL over Avalon-MM, waits for calibration and releases resets.
module tx_rcfg_sequencer #(
   parameter int unsigned RST_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter logic [9:0]  ADDR_CD        = 10'h010,
   parameter logic [9:0]  ADDR_RATIO     = 10'h011,
   parameter logic [9:0]  ADDR_COMMIT    = 10'h000
) (
   input  logic        cpu_clk,
   input  logic        cpu_clk_reset_n,
   input  logic        tx_hpd_req,
   output logic        tx_hpd_ack,
   input  logic [1:0]  color_depth,
   input  logic        tmds_bit_clock_ratio,
   output logic [9:0]  rcfg_address,
   output logic        rcfg_write,
   output logic [31:0] rcfg_writedata,
   input  logic        rcfg_waitrequest,
   input  logic        pll_busy,
   input  logic        pma_cal_busy,
   output logic        tx_rst_pll,
   output logic        tx_rst_xcvr,
   output logic        seq_busy,
   output logic        seq_error
);

   localparam int unsigned MAX_CNT = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
   localparam int          CW      = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RST  = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_PLLW = 3'd3;
   localparam logic [2:0] S_CAL  = 3'd4;
   localparam logic [2:0] S_REL  = 3'd5;
   localparam logic [2:0] S_ACK  = 3'd6;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    wr_idx;
   logic [1:0]    cd_q;
   logic          ratio_q;
   logic          waiting;
   logic          timeout;

   function automatic logic [9:0] wr_addr(input logic [1:0] k);
      case (k)
         2'd0:    return ADDR_CD;
         2'd1:    return ADDR_RATIO;
         default: return ADDR_COMMIT;
      endcase
   endfunction

   function automatic logic [31:0] wr_data(input logic [1:0] k, input logic [1:0] cd,
                                           input logic ratio);
      case (k)
         2'd0:    return {30'b0, cd};
         2'd1:    return {31'b0, ratio};
         default: return 32'h1;
      endcase
   endfunction

   // The shared counter only runs down while a wait state sees no progress.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      waiting = 1'b0;
      case (state)
         S_WR:    waiting = rcfg_waitrequest;
         S_PLLW:  waiting = pll_busy;
         S_CAL:   waiting = pma_cal_busy;
         default: waiting = 1'b0;
      endcase
      timeout = waiting && (cnt == '0);
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_clk_reset_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         wr_idx         <= 2'd0;
         cd_q           <= 2'd0;
         ratio_q        <= 1'b0;
         tx_hpd_ack     <= 1'b0;
         rcfg_write     <= 1'b0;
         rcfg_address   <= 10'h0;
         rcfg_writedata <= 32'h0;
         tx_rst_pll     <= 1'b1;
         tx_rst_xcvr    <= 1'b1;
         seq_busy       <= 1'b0;
         seq_error      <= 1'b0;
      end else if (timeout) begin
         seq_error   <= 1'b1;
         rcfg_write  <= 1'b0;
         tx_rst_pll  <= 1'b1;
         tx_rst_xcvr <= 1'b1;
         tx_hpd_ack  <= 1'b1;
         state       <= S_ACK;
      end else begin
         case (state)
            S_IDLE: begin
               if (tx_hpd_req && !tx_hpd_ack) begin
                  cd_q        <= color_depth;
                  ratio_q     <= tmds_bit_clock_ratio;
                  seq_error   <= 1'b0;
                  tx_rst_pll  <= 1'b1;
                  tx_rst_xcvr <= 1'b1;
                  cnt         <= RST_LOAD;
                  seq_busy    <= 1'b1;
                  state       <= S_RST;
               end
            end
            S_RST: begin
               if (cnt == '0) begin
                  wr_idx         <= 2'd0;
                  rcfg_write     <= 1'b1;
                  rcfg_address   <= wr_addr(2'd0);
                  rcfg_writedata <= wr_data(2'd0, cd_q, ratio_q);
                  cnt            <= TMO_LOAD;
                  state          <= S_WR;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_WR: begin
               if (!rcfg_waitrequest) begin
                  cnt <= TMO_LOAD;
                  if (wr_idx == 2'd2) begin
                     rcfg_write <= 1'b0;
                     tx_rst_pll <= 1'b0;
                     state      <= S_PLLW;
                  end else begin
                     // Next write goes out back-to-back on the following cycle.
                     wr_idx         <= wr_idx + 2'd1;
                     rcfg_address   <= wr_addr(wr_idx + 2'd1);
                     rcfg_writedata <= wr_data(wr_idx + 2'd1, cd_q, ratio_q);
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_PLLW: begin
               if (!pll_busy) begin
                  cnt   <= TMO_LOAD;
                  state <= S_CAL;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_CAL: begin
               if (!pma_cal_busy) begin
                  tx_rst_xcvr <= 1'b0;
                  state       <= S_REL;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_REL: begin
               tx_hpd_ack <= 1'b1;
               state      <= S_ACK;
            end
            S_ACK: begin
               if (!tx_hpd_req) begin
                  tx_hpd_ack <= 1'b0;
                  seq_busy   <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               seq_busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/tx_rcfg_sequencer.md
Name: tx_rcfg_sequencer

Overview:
Hardware sequencer that brings up the HDMI TX path after a hot-plug or mode-change request, without Nios intervention.
- Accepts a 4-phase tx_hpd_req/tx_hpd_ack handshake.
- Asserts the TX PLL and transceiver resets.
- Issues a fixed burst of Avalon-MM writes to the TX PLL reconfiguration management port, built from the sampled color depth and TMDS bit-clock ratio.
- Waits for PLL and PMA calibration to finish, then releases the resets in order.
- Sits between the HDMI TX core status PIOs and the tx_pll reconfig slave; the CPU only observes its status.

Parameters:
RST_CYCLES, 16, cycles both resets are held before the first reconfig write (min 1)
TIMEOUT_CYCLES, 4096, max cycles to wait for waitrequest, pll_busy or pma_cal_busy before declaring error
ADDR_CD, 10'h010, PLL reconfig register address for color depth
ADDR_RATIO, 10'h011, PLL reconfig register address for TMDS bit-clock ratio
ADDR_COMMIT, 10'h000, PLL reconfig commit/start register address

Ports:
cpu_clk  in  1  single clock
cpu_clk_reset_n  in  1  synchronous, active-low reset
tx_hpd_req  in  1  sequence request (level, 4-phase)
tx_hpd_ack  out  1  sequence complete acknowledge
color_depth  in  2  sampled at request acceptance
tmds_bit_clock_ratio  in  1  sampled at request acceptance
rcfg_address  out  10  Avalon-MM address to tx_pll reconfig
rcfg_write  out  1  Avalon-MM write
rcfg_writedata  out  32  Avalon-MM write data
rcfg_waitrequest  in  1  Avalon-MM waitrequest
pll_busy  in  1  PLL reconfig busy/waitrequest status
pma_cal_busy  in  1  PMA calibration busy
tx_rst_pll  out  1  TX PLL reset, active high
tx_rst_xcvr  out  1  TX transceiver reset, active high
seq_busy  out  1  high in any state other than IDLE
seq_error  out  1  sticky timeout flag

Behaviour:
- Interface: one clock, cpu_clk. cpu_clk_reset_n is synchronous and active-low. All outputs are registered.
- Reset values:
  - state IDLE
  - tx_hpd_ack=0, rcfg_write=0, rcfg_address=0, rcfg_writedata=0
  - tx_rst_pll=1, tx_rst_xcvr=1 (TX held in reset until the first sequence completes)
  - seq_busy=0, seq_error=0
- IDLE:
  - Stays in IDLE while tx_hpd_req=0. Resets keep their current values.
  - When tx_hpd_req=1 and tx_hpd_ack=0: latch color_depth and tmds_bit_clock_ratio, clear seq_error, set both resets to 1, load counter=RST_CYCLES-1, go to RST.
- RST: decrement the counter each cycle. At 0, go to WR with write index k=0.
- WR: drive rcfg_write=1 with address/data for write k; hold them stable while rcfg_waitrequest=1.
  - k=0: ADDR_CD, data {30'b0, cd_latched}
  - k=1: ADDR_RATIO, data {31'b0, ratio_latched}
  - k=2: ADDR_COMMIT, data 32'h1
  - The write completes on a cycle with rcfg_write=1 and rcfg_waitrequest=0. Next cycle: k increments with no idle cycle between writes. After k=2, deassert rcfg_write and go to PLLW.
- PLLW: set tx_rst_pll=0. Wait for pll_busy=0, then go to CAL.
- CAL: wait for pma_cal_busy=0, then go to REL.
- REL: set tx_rst_xcvr=0 for one cycle, then go to ACK.
- ACK: tx_hpd_ack=1 until tx_hpd_req=0. Then set ack=0 and go to IDLE. The ack falls the cycle after req is seen low.
- Timeout:
  - One shared counter reloads on entry to WR (per write), PLLW and CAL.
  - If it expires (TIMEOUT_CYCLES cycles without progress): set seq_error=1, drop rcfg_write, keep/force both resets=1, go to ACK.
  - An aborted sequence still acknowledges.
- tx_hpd_req dropping before ACK is ignored; the sequence runs to completion or timeout.
- Reset mid-sequence: immediately returns to reset values. An in-flight write is abandoned (rcfg_write=0 next cycle).
- Inputs are sampled only at request acceptance; changes mid-sequence have no effect.

Test Plan:
- Basic: reset, req=1, cd=2'b10, ratio=1, waitrequest=0, busy inputs 0 → after 16 RST cycles, 3 back-to-back writes (010←2, 011←1, 000←1); tx_rst_pll falls, then tx_rst_xcvr; ack=1; req=0 → ack=0 next cycle.
- Waitrequest stall: waitrequest=1 for 5 cycles on write 1 → address/data/write held stable; no write skipped; total write phase 8 cycles.
- Calibration wait: pma_cal_busy=1 for 100 cycles after the PLL reset release → tx_rst_xcvr stays 1 until cal_busy=0, then falls; seq_error=0.
- Timeout: pll_busy stuck at 1, TIMEOUT_CYCLES=64 → after 64 cycles seq_error=1, both resets=1, ack=1; the next successful request clears seq_error.
- Mid-sequence reset: assert cpu_clk_reset_n=0 during write k=1 with waitrequest=1 → next cycle rcfg_write=0, resets=1, ack=0, seq_busy=0.
- Input change and early req drop: change color_depth and drop req during RST → written data uses the latched value; sequence completes; ack pulses and clears since req is already low.
